usbf_sie_tx: RTL and testbench
==============================

# usbf_sie_tx

SIE transmit packetiser for the USB device core. It accepts a packet request (PID plus a data/handshake flag) from the protocol layer. For data packets it consumes the byte stream produced by the SIE endpoint block (valid/strb/last/accept). It drives the UTMI transmit interface, emitting the PID byte, the payload, and a trailing CRC16, and enforces an inter-packet gap after receive activity.

## Interface

Parameters:
- IPG_CYCLES, 8, minimum idle clocks between `rx_active_i` falling (or own txvalid falling) and the next PID byte; legal range 0..255.

Ports:
- clk_i  in  1  core clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- enable_i  in  1  device enabled; when low, no request is accepted.
- rx_active_i  in  1  UTMI receive active, used for turnaround gap.
- req_i  in  1  packet request; qualified by `req_accept_o`.
- req_pid_i  in  8  full PID byte, including the check nibble, for example 0xC3 DATA0, 0x4B DATA1, 0xD2 ACK.
- req_data_i  in  1  1 = data packet (PID+payload+CRC16); 0 = handshake (PID only).
- req_accept_o  out  1  high in IDLE while `enable_i`; request taken when `req_i && req_accept_o`.
- data_valid_i  in  1  endpoint byte stream valid.
- data_strb_i  in  1  byte present; 0 with last = zero-length packet.
- data_i  in  8  payload byte.
- data_last_i  in  1  final byte (or ZLP marker).
- data_accept_o  out  1  byte consumed this cycle.
- utmi_data_o  out  8  transmit byte.
- utmi_txvalid_o  out  1  transmit valid.
- utmi_txready_i  in  1  PHY accepted `utmi_data_o` this cycle.
- busy_o  out  1  state != IDLE.
- err_o  out  1  one-cycle pulse on payload underrun.

## Operation

States: IDLE, GAP, PID, DATA, CRC_LO, CRC_HI.

- **IDLE**: on an accepted request, latch PID and the data flag. Go to GAP if the gap counter is nonzero, otherwise go to PID.
- **GAP**: wait for the gap counter to reach 0, then go to PID.
- **PID**: `utmi_data_o` = latched PID, `utmi_txvalid_o` = 1. On `utmi_txready_i`:
  - handshake: go to IDLE;
  - data: go to DATA and load the CRC register with 0xFFFF.
- **DATA**:
  - `data_valid_i && !data_strb_i` (ZLP): `data_accept_o` = 1, `utmi_txvalid_o` = 0, go to CRC_LO; CRC unchanged.
  - `data_valid_i && data_strb_i`: `utmi_data_o` = `data_i` (combinational), `utmi_txvalid_o` = 1, `data_accept_o` = `utmi_txready_i`. On accept, update the CRC with `data_i`. If `data_last_i` is also set, go to CRC_LO.
  - `!data_valid_i` (underrun): pulse `err_o`, drop txvalid, go to IDLE. The packet is truncated and the host sees a bad CRC.
- **CRC_LO / CRC_HI**: transmit `~crc[7:0]`, then `~crc[15:8]`. Each byte advances on `utmi_txready_i`. CRC_HI returns to IDLE.
- **CRC16**: polynomial x^16+x^15+x^2+1, reflected (0xA001), LSB-first, init 0xFFFF, output inverted.
- **Gap counter** (8-bit):
  - reloads to IPG_CYCLES while `rx_active_i` or `utmi_txvalid_o` is high;
  - otherwise decrements, saturating at 0.
- `enable_i` low mid-packet does not abort; only `rst_i` aborts.
- A new request is not accepted in the cycle the FSM returns to IDLE; the earliest acceptance is the next cycle.

## Timing

- **Reset** (any state, takes effect at the next edge): state IDLE, gap counter 0, CRC 0xFFFF, latched PID 0. Outputs: `utmi_txvalid_o`=0, `utmi_data_o`=0, `data_accept_o`=0, `busy_o`=0, `err_o`=0, `req_accept_o`=`enable_i`.
- **Request to PID**: the PID is on UTMI the cycle after acceptance when the gap counter is 0, otherwise the cycle after it reaches 0.
- **UTMI hold rule**: `utmi_data_o` and `utmi_txvalid_o` are stable while `utmi_txvalid_o && !utmi_txready_i`.
- **Payload path**: zero added latency from `data_i` to `utmi_data_o`; one byte per `utmi_txready_i` cycle.
- **Back-to-back throughput**: with `utmi_txready_i` held at 1, an N-byte packet occupies N+3 txvalid cycles. A ZLP has one bubble cycle between PID and CRC_LO.
- **Simultaneous events**:
  - `rx_active_i` rising during GAP reloads the counter; the FSM stays in GAP.
  - `req_i` while busy is ignored.

## Structure

- Shared package `usbf_pkg`:
  - PID constants (DATA0/DATA1/ACK/NAK/STALL);
  - CRC16 init (16'hFFFF) and polynomial;
  - state enum for this FSM.
- Sub-module `usbf_crc16`: combinational 8-bit CRC step (crc_in, data_in → crc_out). It is reusable by the receive checker.

## Test plan

- **Handshake**: request ACK (0xD2, `req_data_i`=0), `utmi_txready_i`=1 → exactly one txvalid cycle with data 0xD2; `busy_o` back to 0 the next cycle; `data_accept_o` never asserts.
- **Data packet**: DATA0 with payload 0x31..0x39 ("123456789"), `utmi_txready_i`=1 → UTMI bytes 0xC3, 0x31..0x39, 0xC8, 0xB4; `data_accept_o` high for 9 cycles.
- **ZLP**: DATA1 ZLP → UTMI bytes 0x4B, 0x00, 0x00; `data_accept_o` one cycle with txvalid low.
- **Backpressure**: same payload with `utmi_txready_i` toggling 1/0 → identical byte sequence; data held stable through every stall cycle.
- **Turnaround gap**: `rx_active_i` falls, request accepted the same cycle, IPG_CYCLES=8 → PID appears no earlier than 8 clocks after the fall. A second rx pulse during GAP restarts the count.
- **Underrun and reset**:
  - `data_valid_i` drops after 3 payload bytes → one `err_o` pulse, txvalid low the same cycle, IDLE.
  - Separately, `rst_i` during CRC_LO → all outputs at reset values next cycle; the next request emits a clean packet with correct CRC.

Source files
------------

// File: rtl/usbf_pkg.sv
// Shared definitions for the USB device SIE: PID bytes, CRC16 constants and
// the transmit packetiser state encoding.
package usbf_pkg;

  // Full PID bytes, check nibble included
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // CRC16: x^16+x^15+x^2+1, reflected, LSB first
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;

  // Transmit FSM states (plain constants so older tools read them unchanged)
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_GAP    = 3'd1;
  localparam logic [2:0] TX_PID    = 3'd2;
  localparam logic [2:0] TX_DATA   = 3'd3;
  localparam logic [2:0] TX_CRC_LO = 3'd4;
  localparam logic [2:0] TX_CRC_HI = 3'd5;

endpackage

// File: rtl/usbf_crc16.sv
// One-byte CRC16 step, reflected polynomial, data consumed LSB first.
// Pure combinational so the receive checker can share it.
import usbf_pkg::*;

module usbf_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  // Eight serial shift/xor steps unrolled into one cycle
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data_in[i])
        crc_out = (crc_out >> 1) ^ CRC16_POLY;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/usbf_sie_tx.sv
// SIE transmit packetiser: PID, payload straight from the endpoint stream,
// inverted CRC16 trailer, with an inter-packet gap after bus activity.
import usbf_pkg::*;

module usbf_sie_tx #(
  parameter int IPG_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       rx_active_i,
  input  logic       req_i,
  input  logic [7:0] req_pid_i,
  input  logic       req_data_i,
  output logic       req_accept_o,
  input  logic       data_valid_i,
  input  logic       data_strb_i,
  input  logic [7:0] data_i,
  input  logic       data_last_i,
  output logic       data_accept_o,
  output logic [7:0] utmi_data_o,
  output logic       utmi_txvalid_o,
  input  logic       utmi_txready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [7:0] IPG_LOAD = 8'(IPG_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [7:0]  gap_q;
  logic [7:0]  pid_q;
  logic        data_q;
  logic [15:0] crc_q, crc_next;
  logic        ret_q;     // first IDLE cycle after a packet: no accept yet
  logic        req_take;

  usbf_crc16 u_crc (
    .crc_in  (crc_q),
    .data_in (data_i),
    .crc_out (crc_next)
  );

  assign req_accept_o = (state_q == TX_IDLE) && enable_i && !ret_q;
  assign req_take     = req_i && req_accept_o;
  assign busy_o       = (state_q != TX_IDLE);

  // Next state and UTMI/stream outputs; payload byte passes through unregistered
  always_comb begin
    state_d        = state_q;
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    data_accept_o  = 1'b0;
    err_o          = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (req_take) state_d = (gap_q != 8'd0) ? TX_GAP : TX_PID;
      end
      TX_GAP: begin
        if (gap_q == 8'd0) state_d = TX_PID;
      end
      TX_PID: begin
        utmi_data_o    = pid_q;
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) state_d = data_q ? TX_DATA : TX_IDLE;
      end
      TX_DATA: begin
        if (!data_valid_i) begin
          // Underrun: truncate, the host discards it on the bad CRC
          err_o   = 1'b1;
          state_d = TX_IDLE;
        end else if (!data_strb_i) begin
          // Zero-length marker: swallow it, leaves a one-cycle bubble
          data_accept_o = 1'b1;
          state_d       = TX_CRC_LO;
        end else begin
          utmi_data_o    = data_i;
          utmi_txvalid_o = 1'b1;
          data_accept_o  = utmi_txready_i;
          if (utmi_txready_i && data_last_i) state_d = TX_CRC_LO;
        end
      end
      TX_CRC_LO: begin
        utmi_data_o    = ~crc_q[7:0];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) state_d = TX_CRC_HI;
      end
      TX_CRC_HI: begin
        utmi_data_o    = ~crc_q[15:8];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // FSM state and the one-cycle no-accept window after returning to IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= (state_q != TX_IDLE) && (state_d == TX_IDLE);
    end
  end

  // Gap counter: held at full while the bus is busy, then counts down to 0
  always_ff @(posedge clk_i) begin
    if (rst_i)
      gap_q <= 8'd0;
    else if (rx_active_i || utmi_txvalid_o)
      gap_q <= IPG_LOAD;
    else if (gap_q != 8'd0)
      gap_q <= gap_q - 8'd1;
  end

  // Latched request fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pid_q  <= 8'h00;
      data_q <= 1'b0;
    end else if (req_take) begin
      pid_q  <= req_pid_i;
      data_q <= req_data_i;
    end
  end

  // Running CRC: seeded as the PID leaves, advanced on each accepted byte
  always_ff @(posedge clk_i) begin
    if (rst_i)
      crc_q <= CRC16_INIT;
    else if (state_q == TX_PID && utmi_txready_i)
      crc_q <= CRC16_INIT;
    else if (state_q == TX_DATA && data_accept_o && data_strb_i)
      crc_q <= crc_next;
  end

endmodule

// File: tb/tb_usbf_sie_tx.sv
// Directed bench for usbf_sie_tx: expected UTMI bytes queued at stimulus
// time, a negedge monitor pops and compares every transferred byte.
import usbf_pkg::*;

module tb_usbf_sie_tx;

  logic       clk = 1'b0;
  logic       rst_i, enable_i, rx_active_i;
  logic       req_i, req_data_i, req_accept_o;
  logic [7:0] req_pid_i;
  logic       data_valid_i, data_strb_i, data_last_i, data_accept_o;
  logic [7:0] data_i, utmi_data_o;
  logic       utmi_txvalid_o, utmi_txready_i, busy_o, err_o;

  usbf_sie_tx #(.IPG_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .rx_active_i(rx_active_i),
    .req_i(req_i), .req_pid_i(req_pid_i), .req_data_i(req_data_i),
    .req_accept_o(req_accept_o), .data_valid_i(data_valid_i),
    .data_strb_i(data_strb_i), .data_i(data_i), .data_last_i(data_last_i),
    .data_accept_o(data_accept_o), .utmi_data_o(utmi_data_o),
    .utmi_txvalid_o(utmi_txvalid_o), .utmi_txready_i(utmi_txready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];
  int txv_cnt, acc_cnt, acc_nov, err_cnt, hold_cnt;
  int first_tx, last_tx, err_cyc;
  bit bp = 0, done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic clr();
    txv_cnt = 0; acc_cnt = 0; acc_nov = 0; err_cnt = 0; hold_cnt = 0;
    first_tx = -1; last_tx = -1; err_cyc = -1;
  endtask

  // Advance one clock; inputs change just after the edge
  task automatic tick();
    @(posedge clk); #1;
    if (bp) utmi_txready_i = ~utmi_txready_i;
  endtask

  task automatic do_req(input logic [7:0] pid, input bit isdata, output int ac);
    int g = 0;
    req_i = 1'b1; req_pid_i = pid; req_data_i = isdata;
    @(negedge clk);
    while (!req_accept_o && g < 200) begin tick(); @(negedge clk); g++; end
    ac = cyc;
    if (!req_accept_o) fail("req_accept_timeout");
    tick();
    req_i = 1'b0;
  endtask

  // Endpoint model: presents pl_q, advancing on data_accept_o. With
  // last_flag clear the stream just runs dry (underrun); empty + last = ZLP.
  task automatic drive_stream(input bit last_flag);
    int g = 0;
    bit acc, fin = 0;
    while (!fin && g < 400) begin
      if (pl_q.size() == 0 && !last_flag) begin
        data_valid_i = 1'b0;
        fin = 1;
      end else begin
        data_valid_i = 1'b1;
        data_strb_i  = (pl_q.size() != 0);
        data_i       = (pl_q.size() != 0) ? pl_q[0] : 8'h00;
        data_last_i  = last_flag && (pl_q.size() <= 1);
        @(negedge clk);
        acc = data_accept_o;
        tick();
        g++;
        if (acc) begin
          if (data_last_i) fin = 1;
          if (pl_q.size() != 0) void'(pl_q.pop_front());
        end
      end
    end
    data_valid_i = 1'b0; data_strb_i = 1'b0; data_last_i = 1'b0; data_i = 8'h00;
    if (!fin) fail("stream_timeout");
  endtask

  task automatic wait_idle(output int c);
    int g = 0;
    @(negedge clk);
    while (busy_o && g < 500) begin tick(); @(negedge clk); g++; end
    c = cyc;
    if (busy_o) fail("idle_timeout");
  endtask

  task automatic monitor();
    logic       prev_stall = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] e;
    while (!done) begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (prev_stall) begin
          hold_cnt++;
          chk("hold_txvalid", utmi_txvalid_o, 1);
          chk("hold_data", utmi_data_o, prev_data);
        end
        if (busy_o) chk("accept_while_busy", req_accept_o, 0);
        if (prev_busy && !busy_o) chk("accept_on_return", req_accept_o, 0);
        if (utmi_txvalid_o) begin
          txv_cnt++;
          if (first_tx < 0) first_tx = cyc;
          last_tx = cyc;
        end
        if (utmi_txvalid_o && utmi_txready_i) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL utmi_extra: got %0h expected none", utmi_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("utmi_byte", utmi_data_o, e);
          end
        end
        if (data_accept_o) begin
          acc_cnt++;
          if (!utmi_txvalid_o) acc_nov++;
        end
        if (err_o) begin
          err_cnt++;
          err_cyc = cyc;
          chk("err_txvalid", utmi_txvalid_o, 0);
        end
        prev_stall = utmi_txvalid_o && !utmi_txready_i;
        prev_data  = utmi_data_o;
        prev_busy  = busy_o;
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_txvalid"}, utmi_txvalid_o, 0);
    chk({tag, "_data"}, utmi_data_o, 0);
    chk({tag, "_accept"}, data_accept_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_req_accept"}, req_accept_o, 1);
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) begin
      pl_q.push_back(8'h31 + 8'(i));
      exp_q.push_back(8'h31 + 8'(i));
    end
  endtask

  task automatic run_tests();
    int ac, ic;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    enable_i = 1'b0; #1;
    chk("disabled_req_accept", req_accept_o, 0);
    enable_i = 1'b1;
    tick(); rst_i = 1'b0; tick();

    // handshake ACK
    clr(); exp_q.push_back(PID_ACK);
    do_req(PID_ACK, 0, ac); wait_idle(ic);
    chk("ack_txv_cycles", txv_cnt, 1);
    chk("ack_latency", first_tx - ac, 1);
    chk("ack_busy_drop", ic - last_tx, 1);
    chk("ack_accepts", acc_cnt, 0);
    chk("ack_queue", exp_q.size(), 0);

    // DATA0 "123456789", txready held high
    clr(); exp_q.push_back(PID_DATA0); load_digits();
    exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
    do_req(PID_DATA0, 1, ac); drive_stream(1); wait_idle(ic);
    chk("data_accepts", acc_cnt, 9);
    chk("data_txv_cycles", txv_cnt, 12);
    chk("data_span", last_tx - first_tx, 11);
    chk("data_queue", exp_q.size(), 0);
    chk("data_err", err_cnt, 0);

    // DATA1 zero-length packet
    clr(); exp_q.push_back(PID_DATA1); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    do_req(PID_DATA1, 1, ac); drive_stream(1); wait_idle(ic);
    chk("zlp_accepts", acc_cnt, 1);
    chk("zlp_accept_no_txvalid", acc_nov, 1);
    chk("zlp_txv_cycles", txv_cnt, 3);
    chk("zlp_span", last_tx - first_tx, 3);
    chk("zlp_queue", exp_q.size(), 0);

    // same payload with txready toggling
    clr(); exp_q.push_back(PID_DATA0); load_digits();
    exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
    bp = 1;
    do_req(PID_DATA0, 1, ac); drive_stream(1); wait_idle(ic);
    bp = 0; utmi_txready_i = 1'b1;
    chk("bp_accepts", acc_cnt, 9);
    chk("bp_queue", exp_q.size(), 0);
    chk("bp_stalls_seen", hold_cnt != 0, 1);

    // turnaround gap: accept in the cycle rx_active falls
    tick(); rx_active_i = 1'b1; tick(); tick(); tick();
    rx_active_i = 1'b0;
    clr(); exp_q.push_back(PID_NAK);
    do_req(PID_NAK, 0, ac); wait_idle(ic);
    chk("gap_latency", first_tx - ac, 9);
    chk("gap_queue", exp_q.size(), 0);

    // second rx pulse inside GAP restarts the count
    rx_active_i = 1'b1; tick(); rx_active_i = 1'b0;
    clr(); exp_q.push_back(PID_STALL);
    do_req(PID_STALL, 0, ac);
    tick(); tick(); tick();
    rx_active_i = 1'b1; tick(); rx_active_i = 1'b0;
    wait_idle(ic);
    chk("gap_restart_latency", first_tx - ac, 14);
    chk("gap_restart_queue", exp_q.size(), 0);

    // underrun after 3 bytes
    clr(); exp_q.push_back(PID_DATA0);
    pl_q = '{8'h11, 8'h22, 8'h33};
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    do_req(PID_DATA0, 1, ac); drive_stream(0); wait_idle(ic);
    chk("underrun_err_pulses", err_cnt, 1);
    chk("underrun_accepts", acc_cnt, 3);
    chk("underrun_idle", ic - err_cyc, 1);
    chk("underrun_queue", exp_q.size(), 0);

    // reset while in CRC_LO
    clr(); exp_q.push_back(PID_DATA0); exp_q.push_back(8'hAB);
    pl_q = '{8'hAB};
    do_req(PID_DATA0, 1, ac); drive_stream(1);
    utmi_txready_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    chk("crc_lo_txvalid", utmi_txvalid_o, 1);
    tick(); @(negedge clk);
    chk_reset_outs("midreset");
    chk("midreset_queue", exp_q.size(), 0);
    tick(); rst_i = 1'b0; utmi_txready_i = 1'b1;

    // clean packet afterwards
    clr(); exp_q.push_back(PID_DATA1); load_digits();
    exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
    do_req(PID_DATA1, 1, ac); drive_stream(1); wait_idle(ic);
    chk("post_reset_latency", first_tx - ac, 1);
    chk("post_reset_accepts", acc_cnt, 9);
    chk("post_reset_queue", exp_q.size(), 0);

    done = 1;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; rx_active_i = 1'b0;
    req_i = 1'b0; req_pid_i = 8'h00; req_data_i = 1'b0;
    data_valid_i = 1'b0; data_strb_i = 1'b0; data_i = 8'h00; data_last_i = 1'b0;
    utmi_txready_i = 1'b1;
    clr();
    fork
      monitor();
      run_tests();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
